// File: rtl/mips_muldiv_if.sv
// Core-side bus of the HI/LO multiply/divide unit: operation request, MTHI/MTLO
// writes, and the busy/done/HI/LO results the pipeline reads back.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative radix-2 MIPS multiply/divide unit with HI/LO registers:
// shift-add multiply and restoring divide on magnitudes, one bit per clock.
module mips_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic         clk,
    input logic         rst,
    mips_muldiv_if.slave bus
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               is_div_reg;
    logic               neg_main_reg;
    logic               neg_rem_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   a_mag_reg;
    logic [WIDTH-1:0]   b_mag_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   rem_reg;

    // Operand preparation at the start edge: signed ops work on magnitudes.
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    always_comb begin
        in_signed = ~bus.op[0];
        a_neg     = in_signed & bus.src_a[WIDTH-1];
        b_neg     = in_signed & bus.src_b[WIDTH-1];
        a_mag_in  = a_neg ? -bus.src_a : bus.src_a;
        b_mag_in  = b_neg ? -bus.src_b : bus.src_b;
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, a_mag_reg} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end

    // Divide step: acc low half holds dividend bits shifting out, quotient bits in.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ok;

    always_comb begin
        div_shift = {rem_reg, acc_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_reg};
        div_ok    = ~div_diff[WIDTH];
    end

    // Final sign fixup and HI/LO selection.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod_fix = neg_main_reg ? -acc_reg : acc_reg;
        quot_fix = neg_main_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = neg_rem_reg ? -rem_reg : rem_reg;
        if (!is_div_reg) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero_reg) begin
            fin_hi = a_raw_reg;
            fin_lo = {WIDTH{1'b1}};
        end else begin
            fin_hi = rem_fix;
            fin_lo = quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            a_mag_reg    <= '0;
            b_mag_reg    <= '0;
            a_raw_reg    <= '0;
            acc_reg      <= '0;
            rem_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        // A start in the same cycle as MTHI/MTLO drops the MT write.
                        is_div_reg   <= bus.op[1];
                        neg_main_reg <= a_neg ^ b_neg;
                        neg_rem_reg  <= a_neg;
                        div_zero_reg <= (bus.src_b == '0);
                        a_mag_reg    <= a_mag_in;
                        b_mag_reg    <= b_mag_in;
                        a_raw_reg    <= bus.src_a;
                        acc_reg      <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag_in}
                                                  : {{WIDTH{1'b0}}, b_mag_in};
                        rem_reg      <= '0;
                        count_reg    <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end else begin
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                RUN: begin
                    count_reg <= count_reg + 1'b1;
                    if (is_div_reg) begin
                        rem_reg <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], div_ok};
                    end else begin
                        acc_reg <= mul_next;
                    end
                    if (count_reg == CW'(ITER - 1)) state_reg <= FIN;
                end
                FIN: begin
                    hi_reg    <= fin_hi;
                    lo_reg    <= fin_lo;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: hand-computed products/quotients, latency,
// MT writes, ignored start/MT during busy, and reset mid-operation.
module tb_mips_muldiv;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv #(.WIDTH(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a start for one cycle, then scramble operands to prove they are latched.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        bus.op    = 2'($urandom);
    endtask

    // Wait out busy (bounded), then check latency, done pulse and results.
    task automatic finish_op(input string tag, input int already,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int early_done;
        n = already;
        early_done = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (bus.done) early_done++;
            tick();
        end
        chk({tag, "/busy_cycles"}, 32'(n), 32'd33);
        chk({tag, "/early_done"}, 32'(early_done), 32'd0);
        chk({tag, "/done"}, 32'(bus.done), 32'd1);
        chk({tag, "/hi"}, bus.hi, exp_hi);
        chk({tag, "/lo"}, bus.lo, exp_lo);
        $display("%s: hi=%h lo=%h busy_cycles=%0d", tag, bus.hi, bus.lo, n);
        tick();
        chk({tag, "/done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, "/idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        int busies;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset/busy", 32'(bus.busy), 32'd0);
        chk("reset/done", 32'(bus.done), 32'd0);
        chk("reset/hi", bus.hi, 32'h0);
        chk("reset/lo", bus.lo, 32'h0);

        // MTHI alone, then MTHI+MTLO together
        bus.hi_we = 1'b1;
        bus.wdata = 32'h12345678;
        tick();
        bus.hi_we = 1'b0;
        chk("mthi/hi", bus.hi, 32'h12345678);
        chk("mthi/lo", bus.lo, 32'h0);
        $display("mthi: hi=%h lo=%h", bus.hi, bus.lo);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mt_both/hi", bus.hi, 32'hA5A5A5A5);
        chk("mt_both/lo", bus.lo, 32'hA5A5A5A5);
        $display("mt_both: hi=%h lo=%h", bus.hi, bus.lo);

        // MULT -3 * 5, old HI/LO must stay visible while running
        launch(2'b00, 32'hFFFFFFFD, 32'd5);
        chk("mult_neg/hold_hi", bus.hi, 32'hA5A5A5A5);
        chk("mult_neg/hold_lo", bus.lo, 32'hA5A5A5A5);
        finish_op("mult_neg", 0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu_max", 0, 32'hFFFFFFFE, 32'h00000001);

        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("mult_m1", 0, 32'h0, 32'h1);

        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        finish_op("div_neg", 0, 32'hFFFFFFFF, 32'hFFFFFFFD);

        launch(2'b11, 32'd100, 32'd7);
        finish_op("divu", 0, 32'd2, 32'd14);

        launch(2'b11, 32'h64, 32'h0);
        finish_op("divu_zero", 0, 32'h64, 32'hFFFFFFFF);

        launch(2'b10, 32'hFFFFFFF9, 32'h0);
        finish_op("div_zero_neg", 0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_ovf", 0, 32'h0, 32'h80000000);

        // start together with MTHI in idle: MTHI dropped (hi still 0 from div_ovf)
        bus.hi_we = 1'b1;
        bus.wdata = 32'h55555555;
        launch(2'b01, 32'd6, 32'd7);
        bus.hi_we = 1'b0;
        chk("start_mthi/hi", bus.hi, 32'h0);
        finish_op("start_mthi", 0, 32'h0, 32'd42);

        // start re-asserted at busy cycle 10 is ignored; no second operation
        launch(2'b01, 32'd6, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        bus.op    = 2'b11;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_op("restart_ignored", 10, 32'h0, 32'd42);
        busies = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy || bus.done) busies++;
            tick();
        end
        chk("restart_ignored/no_queue", 32'(busies), 32'd0);

        // MTLO during busy is ignored
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFEBABE;
        tick();
        bus.lo_we = 1'b0;
        chk("mtlo_idle/lo", bus.lo, 32'hCAFEBABE);
        launch(2'b11, 32'd100, 32'd7);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        tick();
        bus.lo_we = 1'b0;
        chk("mtlo_busy/lo", bus.lo, 32'hCAFEBABE);
        finish_op("mtlo_busy", 1, 32'd2, 32'd14);

        // reset at busy cycle 20 of a DIV
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid/busy", 32'(bus.busy), 32'd0);
        chk("rst_mid/done", 32'(bus.done), 32'd0);
        chk("rst_mid/hi", bus.hi, 32'h0);
        chk("rst_mid/lo", bus.lo, 32'h0);
        dones = 0;
        busies = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            if (bus.busy) busies++;
            tick();
        end
        chk("rst_mid/no_done", 32'(dones), 32'd0);
        chk("rst_mid/no_busy", 32'(busies), 32'd0);
        chk("rst_mid/hi_after", bus.hi, 32'h0);
        chk("rst_mid/lo_after", bus.lo, 32'h0);
        $display("rst_mid: hi=%h lo=%h dones=%0d", bus.hi, bus.lo, dones);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
